// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD bus arbiter slice: init command table,
// controller state encoding and transfer geometry.
package lcd_pkg;

    typedef logic [7:0] lcd_byte_t;

    typedef enum logic [1:0] {
        ST_PWRUP_WAIT = 2'd0,
        ST_INIT_XFER  = 2'd1,
        ST_IDLE       = 2'd2,
        ST_XFER       = 2'd3
    } lcd_state_e;

    localparam lcd_byte_t CMD_CLEAR    = 8'h01;
    localparam lcd_byte_t CMD_FUNC_SET = 8'h38;
    localparam lcd_byte_t CMD_ENTRY    = 8'h06;
    localparam lcd_byte_t CMD_DISP_ON  = 8'h0C;

    localparam int         INIT_LEN   = 4;
    localparam logic [1:0] INIT_LAST  = 2'(INIT_LEN - 1);
    localparam int         XFER_SLOTS = 4;

    function automatic lcd_byte_t init_cmd(input logic [1:0] idx);
        lcd_byte_t cmd;
        case (idx)
            2'd1:    cmd = CMD_FUNC_SET;
            2'd2:    cmd = CMD_ENTRY;
            2'd3:    cmd = CMD_DISP_ON;
            default: cmd = CMD_CLEAR;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester handshake and LCD pin bundle; master = requesters/pins side,
// slave = the arbiter.
interface lcd_bus_arbiter_if;
    import lcd_pkg::*;

    logic      req0_valid;
    logic      req0_rs;
    lcd_byte_t req0_data;
    logic      req0_ready;
    logic      req1_valid;
    logic      req1_rs;
    lcd_byte_t req1_data;
    logic      req1_ready;
    logic      init_done;
    logic      busy;
    logic      lcd_e;
    logic      lcd_rs;
    logic      lcd_rw;
    lcd_byte_t lcd_data;

    modport master (
        output req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
        input  req0_ready, req1_ready, init_done, busy, lcd_e, lcd_rs, lcd_rw, lcd_data
    );

    modport slave (
        input  req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
        output req0_ready, req1_ready, init_done, busy, lcd_e, lcd_rs, lcd_rw, lcd_data
    );

endinterface

// File: rtl/lcd_slot_timer.sv
// 1 ms slot prescaler: counts CNT1MS-cycle slots up to last_slot, then pulses done
// and wraps. Restart holds it at slot 0 / cycle 0.
module lcd_slot_timer #(
    parameter int CNT1MS = 100000,
    parameter int SLOT_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic [SLOT_W-1:0] last_slot,
    output logic [SLOT_W-1:0] slot,
    output logic              tick,
    output logic              done
);

    localparam int CNT_W = (CNT1MS > 1) ? $clog2(CNT1MS) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CNT1MS - 1));
    assign done = tick && (slot == last_slot);

    // NOTE: non-blocking assignments so every flop here samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            slot <= '0;
        end else if (restart || done) begin
            cnt  <= '0;
            slot <= '0;
        end else if (tick) begin
            cnt  <= '0;
            slot <= slot + 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Character-LCD write-port controller: optional power-up init (LCD_ARB_INIT_EN),
// then round-robin sharing of one E-strobed write port between two requesters.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int CNT1MS   = 100000,
    parameter int PWRUP_MS = 100
) (
    input logic              clk,
    input logic              reset,
    lcd_bus_arbiter_if.slave bus
);

    localparam int SLOT_W = $clog2((PWRUP_MS > XFER_SLOTS) ? PWRUP_MS : XFER_SLOTS);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] XFER = ST_XFER;
`ifdef LCD_ARB_INIT_EN
    localparam logic [1:0] PWRUP_WAIT  = ST_PWRUP_WAIT;
    localparam logic [1:0] INIT_XFER   = ST_INIT_XFER;
    localparam logic [1:0] RESET_STATE = ST_PWRUP_WAIT;
`else
    localparam logic [1:0] RESET_STATE = ST_IDLE;
`endif

    logic [1:0]        state;
    logic              busy_q;
    logic              init_done_q;
    logic              last_port;
    logic              lcd_e_q;
    logic              lcd_rs_q;
    lcd_byte_t         lcd_data_q;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] last_slot;
    logic              tick;
    logic              done;
    logic              xfer_active;
    logic              grant;
    logic              grant_port;

`ifdef LCD_ARB_INIT_EN
    logic [1:0] init_idx;

    assign xfer_active = (state == XFER) || (state == INIT_XFER);
    assign last_slot   = (state == PWRUP_WAIT) ? SLOT_W'(PWRUP_MS - 1) : SLOT_W'(XFER_SLOTS - 1);
`else
    assign xfer_active = (state == XFER);
    assign last_slot   = SLOT_W'(XFER_SLOTS - 1);
`endif

    lcd_slot_timer #(
        .CNT1MS (CNT1MS),
        .SLOT_W (SLOT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .restart   (state == IDLE),
        .last_slot (last_slot),
        .slot      (slot),
        .tick      (tick),
        .done      (done)
    );

    // Both pending: serve the port that did not win last time.
    assign grant_port = bus.req1_valid && (!bus.req0_valid || !last_port);
    // busy_q also masks the first IDLE cycle after reset in the no-init build.
    assign grant      = (state == IDLE) && !busy_q && (bus.req0_valid || bus.req1_valid);

    assign bus.req0_ready = grant && !grant_port;
    assign bus.req1_ready = grant && grant_port;
    assign bus.init_done  = init_done_q;
    assign bus.busy       = busy_q;
    assign bus.lcd_e      = lcd_e_q;
    assign bus.lcd_rs     = lcd_rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_data   = lcd_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RESET_STATE;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            last_port   <= 1'b1;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= '0;
`ifdef LCD_ARB_INIT_EN
            init_idx    <= '0;
`endif
        end else begin
            // E is registered and toggles only on slot boundaries, so it never glitches.
            if (xfer_active && tick) lcd_e_q <= (slot == '0);

            case (state)
`ifdef LCD_ARB_INIT_EN
                PWRUP_WAIT: if (done) begin
                    state      <= INIT_XFER;
                    init_idx   <= '0;
                    lcd_rs_q   <= 1'b0;
                    lcd_data_q <= init_cmd(2'd0);
                end
                INIT_XFER: if (done) begin
                    if (init_idx == INIT_LAST) begin
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        init_idx   <= init_idx + 1'b1;
                        lcd_data_q <= init_cmd(init_idx + 1'b1);
                    end
                end
`endif
                IDLE: begin
                    busy_q <= grant;
                    if (grant) begin
                        state      <= XFER;
                        last_port  <= grant_port;
                        lcd_rs_q   <= grant_port ? bus.req1_rs : bus.req0_rs;
                        lcd_data_q <= grant_port ? bus.req1_data : bus.req0_data;
                    end
                end
                XFER: if (done) begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Randomized requesters against a cycle-arithmetic reference model of the LCD arbiter;
// covers power-up, contention, hold-off and reset mid-transfer.
module tb_lcd_bus_arbiter;

    localparam int C        = 10;
    localparam int PW       = 5;
    localparam int XL       = 4 * C;
    localparam int INIT_END = PW * C + 4 * XL;
`ifdef LCD_ARB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lcd_bus_arbiter_if bus ();

    lcd_bus_arbiter #(
        .CNT1MS   (C),
        .PWRUP_MS (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cycle;
    int mode;

    logic [7:0] init_tbl [4] = '{8'h01, 8'h38, 8'h06, 8'h0C};

    // requester state
    bit         v    [2];
    bit         rsb  [2];
    logic [7:0] d    [2];
    bit         seen [2];

    // reference model: effects of everything accepted so far
    logic [7:0] m_data;
    bit         m_rs;
    int         m_xs;
    bit         m_xs_valid;
    bit         m_xs_user;
    bit         m_last;
    int         m_free_at;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic model_reset();
        cycle      = 0;
        m_data     = 8'h00;
        m_rs       = 1'b0;
        m_xs       = 0;
        m_xs_valid = 1'b0;
        m_xs_user  = 1'b0;
        m_last     = 1'b1;
        m_free_at  = INIT_EN ? INIT_END : 1;
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < 2; p++) begin
            if (seen[p]) begin
                v[p]    = 1'b0;
                seen[p] = 1'b0;
            end
            if (!v[p] && (mode == 1 || $urandom_range(0, 99) < 20)) begin
                v[p]   = 1'b1;
                rsb[p] = 1'($urandom_range(0, 1));
                d[p]   = 8'($urandom);
            end
        end
        bus.req0_valid = v[0];
        bus.req0_rs    = rsb[0];
        bus.req0_data  = d[0];
        bus.req1_valid = v[1];
        bus.req1_rs    = rsb[1];
        bus.req1_data  = d[1];
    endtask

    task automatic check_cycle();
        bit exp_e;
        bit acc;
        int port;
        exp_e = m_xs_valid && cycle >= m_xs + C && cycle < m_xs + 2 * C;
        check("lcd_e",     32'(bus.lcd_e),     32'(exp_e));
        check("lcd_data",  32'(bus.lcd_data),  32'(m_data));
        check("lcd_rs",    32'(bus.lcd_rs),    32'(m_rs));
        check("lcd_rw",    32'(bus.lcd_rw),    32'(1'b0));
        check("busy",      32'(bus.busy),      32'(cycle < m_free_at));
        check("init_done", 32'(bus.init_done), 32'(INIT_EN && cycle >= INIT_END));

        acc  = (cycle >= m_free_at) && (v[0] || v[1]);
        port = (v[0] && v[1]) ? (m_last ? 0 : 1) : (v[1] ? 1 : 0);
        check("ready0", 32'(bus.req0_ready), 32'(acc && port == 0));
        check("ready1", 32'(bus.req1_ready), 32'(acc && port == 1));
        if (bus.req0_ready) seen[0] = 1'b1;
        if (bus.req1_ready) seen[1] = 1'b1;

        if (acc) begin
            m_last     = (port == 1);
            m_data     = d[port];
            m_rs       = rsb[port];
            m_xs       = cycle + 1;
            m_xs_valid = 1'b1;
            m_xs_user  = 1'b1;
            m_free_at  = cycle + XL + 1;
        end
        // init commands start back-to-back right after the power-up wait
        if (INIT_EN && cycle >= PW * C - 1 && cycle < INIT_END - 1 && (cycle - (PW * C - 1)) % XL == 0) begin
            m_data     = init_tbl[(cycle - (PW * C - 1)) / XL];
            m_rs       = 1'b0;
            m_xs       = cycle + 1;
            m_xs_valid = 1'b1;
            m_xs_user  = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        cycle++;
        #2;
        drive_inputs();
    endtask

    task automatic restart_from_reset();
        reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            v[p]    = 1'b0;
            seen[p] = 1'b0;
            rsb[p]  = 1'b0;
            d[p]    = 8'h00;
        end
        drive_inputs();
        repeat (3) @(posedge clk);
        #2;
        model_reset();
        mode = 0;
        drive_inputs();
        reset = 1'b1;
    endtask

    initial begin
        int budget;
        mode = 0;
        restart_from_reset();

        // random traffic, including requests held off during init
        repeat (700) step();

        // both ports permanently pending: grants must alternate
        mode = 1;
        repeat (300) step();

        // reset in the middle of a requester transfer, at k=12 with E high
        budget = 400;
        while (!(m_xs_user && cycle == m_xs + 12) && budget > 0) begin
            step();
            budget--;
        end
        check("rst_reach_k12", 32'(budget > 0), 32'(1'b1));
        check("e_before_rst",  32'(bus.lcd_e),  32'(1'b1));
        reset = 1'b0;
        #1;
        check("rst_lcd_e",     32'(bus.lcd_e),      32'(1'b0));
        check("rst_lcd_data",  32'(bus.lcd_data),   32'(8'h00));
        check("rst_lcd_rs",    32'(bus.lcd_rs),     32'(1'b0));
        check("rst_ready0",    32'(bus.req0_ready), 32'(1'b0));
        check("rst_ready1",    32'(bus.req1_ready), 32'(1'b0));
        check("rst_busy",      32'(bus.busy),       32'(1'b1));
        check("rst_init_done", 32'(bus.init_done),  32'(1'b0));

        // the whole sequence restarts from scratch
        restart_from_reset();
        repeat (300) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
